// File: rtl/mem_response_router.sv
// mem_response_router: return path of the page access counter memory path.
// Every issued request leaves its granted port index in an in-order tag FIFO.
// In-order memory responses pop that FIFO and are steered to the recorded
// port through a single-entry output register with a valid/ready handshake.
module mem_response_router #(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_issue_valid,
    input  logic [NUM_PORTS-1:0]                 i_issue_grant,
    output logic                                 o_issue_ready,
    input  logic                                 i_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                i_rsp_data,
    output logic                                 o_rsp_ready,
    output logic [NUM_PORTS-1:0]                 o_out_valid,
    output logic [DATA_WIDTH-1:0]                o_out_data,
    input  logic [NUM_PORTS-1:0]                 i_out_ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding_cnt,
    output logic                                 o_err_unexpected_rsp,
    output logic                                 o_err_bad_grant
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    logic [TW-1:0]         r_tags [MAX_OUTSTANDING];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_hold_valid;
    logic [TW-1:0]         r_hold_port;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_err_unexp;
    logic                  r_err_bad;

    logic                  w_full;
    logic                  w_empty;
    logic [TW-1:0]         w_tag;
    logic                  w_grant_multi;
    logic                  w_grant_bad;
    logic                  w_push;
    logic                  w_sel_ready;
    logic                  w_rsp_ready;
    logic                  w_rsp_acc;
    logic                  w_pop;
    logic                  w_release;

    assign w_full        = (r_cnt == FULL_CNT);
    assign w_empty       = (r_cnt == '0);
    assign w_grant_multi = ((i_issue_grant & (i_issue_grant - NUM_PORTS'(1))) != '0);
    assign w_grant_bad   = (i_issue_grant == '0) || w_grant_multi;
    assign w_push        = i_issue_valid && !w_full && (i_issue_grant != '0);

    // Lowest set grant bit wins, mirroring the arbiter's fixed priority.
    always_comb begin
        w_tag = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (i_issue_grant[i]) w_tag = TW'(i);
        end
    end

    // Ready of the port currently owning the held response.
    always_comb begin
        w_sel_ready = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_hold_port == TW'(p)) w_sel_ready = i_out_ready[p];
        end
    end

    assign w_release   = r_hold_valid && w_sel_ready;
    assign w_rsp_ready = !r_hold_valid || w_sel_ready;
    assign w_rsp_acc   = i_rsp_valid && w_rsp_ready;
    assign w_pop       = w_rsp_acc && !w_empty;

    // Decode the held port onto the one-hot valid vector.
    always_comb begin
        o_out_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_out_valid[p] = r_hold_valid && (r_hold_port == TW'(p));
        end
    end

    // Tag storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) r_tags[r_wptr] <= w_tag;
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Output hold register: reload on pop (even during release), else clear on release.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_valid <= 1'b0;
            r_hold_port  <= '0;
            r_hold_data  <= '0;
        end else if (w_pop) begin
            r_hold_valid <= 1'b1;
            r_hold_port  <= r_tags[r_rptr];
            r_hold_data  <= i_rsp_data;
        end else if (w_release) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_unexp <= 1'b0;
            r_err_bad   <= 1'b0;
        end else begin
            if (w_rsp_acc && w_empty)         r_err_unexp <= 1'b1;
            if (i_issue_valid && w_grant_bad) r_err_bad   <= 1'b1;
        end
    end

    assign o_issue_ready        = !w_full;
    assign o_rsp_ready          = w_rsp_ready;
    assign o_out_data           = r_hold_data;
    assign o_outstanding_cnt    = r_cnt;
    assign o_err_unexpected_rsp = r_err_unexp;
    assign o_err_bad_grant      = r_err_bad;

endmodule

// File: tb/tb_mem_response_router.sv
// Testbench for mem_response_router: directed scenarios plus a random phase,
// checked against a queue-based reference model and an output scoreboard.
module tb_mem_response_router;

    localparam int NP  = 2;
    localparam int DW  = 512;
    localparam int MO  = 16;
    localparam int CW  = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_issue_valid;
    logic [NP-1:0] i_issue_grant;
    logic          o_issue_ready;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          o_rsp_ready;
    logic [NP-1:0] o_out_valid;
    logic [DW-1:0] o_out_data;
    logic [NP-1:0] i_out_ready;
    logic [CW-1:0] o_outstanding_cnt;
    logic          o_err_unexpected_rsp;
    logic          o_err_bad_grant;

    mem_response_router #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .i_clk                (clk),
        .i_reset              (i_reset),
        .i_issue_valid        (i_issue_valid),
        .i_issue_grant        (i_issue_grant),
        .o_issue_ready        (o_issue_ready),
        .i_rsp_valid          (i_rsp_valid),
        .i_rsp_data           (i_rsp_data),
        .o_rsp_ready          (o_rsp_ready),
        .o_out_valid          (o_out_valid),
        .o_out_data           (o_out_data),
        .i_out_ready          (i_out_ready),
        .o_outstanding_cnt    (o_outstanding_cnt),
        .o_err_unexpected_rsp (o_err_unexpected_rsp),
        .o_err_bad_grant      (o_err_bad_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    int            n_checks = 0;
    int            n_errors = 0;

    // Reference model state: outstanding tags, expected deliveries, hold, flags.
    int            mq[$];
    exp_t          expq[$];
    bit            m_hv;
    int            m_hp;
    logic [DW-1:0] m_hd;
    bit            m_eu;
    bit            m_eb;

    task automatic check(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [NP-1:0] rnd_onehot();
        logic [NP-1:0] g;
        g = '0;
        g[$urandom_range(NP - 1, 0)] = 1'b1;
        return g;
    endfunction

    // Reference model: checks every visible output, then advances one cycle.
    always @(negedge clk) begin
        int  sz0;
        bit  rr;
        bit  acc;
        int  tag;
        int  nbits;
        if (i_reset) begin
            mq.delete();
            expq.delete();
            m_hv = 0;
            m_hp = 0;
            m_hd = '0;
            m_eu = 0;
            m_eb = 0;
        end else begin
            sz0 = mq.size();
            rr  = !m_hv || i_out_ready[m_hp];
            check("issue_ready", longint'(o_issue_ready), longint'(sz0 < MO));
            check("outstanding_cnt", longint'(o_outstanding_cnt), longint'(sz0));
            check("out_valid", longint'(o_out_valid), m_hv ? (longint'(1) << m_hp) : 0);
            check("rsp_ready", longint'(o_rsp_ready), longint'(rr));
            check("err_unexpected_rsp", longint'(o_err_unexpected_rsp), longint'(m_eu));
            check("err_bad_grant", longint'(o_err_bad_grant), longint'(m_eb));
            check_data("out_data", o_out_data, m_hd);

            acc = i_rsp_valid && rr;
            if (acc && sz0 > 0) begin
                tag  = mq.pop_front();
                m_hv = 1;
                m_hp = tag;
                m_hd = i_rsp_data;
                expq.push_back('{port: tag, data: i_rsp_data});
            end else begin
                if (acc) m_eu = 1;
                if (m_hv && i_out_ready[m_hp]) m_hv = 0;
            end

            if (i_issue_valid) begin
                nbits = 0;
                tag   = -1;
                for (int i = 0; i < NP; i++) begin
                    if (i_issue_grant[i]) begin
                        nbits++;
                        if (tag < 0) tag = i;
                    end
                end
                if (nbits != 1) m_eb = 1;
                if (sz0 < MO && nbits > 0) mq.push_back(tag);
            end
        end
    end

    // Scoreboard monitor: every completed output handshake must match the next expected delivery.
    always @(negedge clk) begin
        logic [NP-1:0] fire;
        int            port;
        exp_t          e;
        if (!i_reset) begin
            fire = o_out_valid & i_out_ready;
            if (fire != '0) begin
                port = 0;
                for (int i = NP - 1; i >= 0; i--) if (fire[i]) port = i;
                if (expq.size() == 0) begin
                    check("delivery_expected", longint'(fire), 0);
                end else begin
                    e = expq.pop_front();
                    check("delivery_port", longint'(port), longint'(e.port));
                    check_data("delivery_data", o_out_data, e.data);
                end
            end
        end
    end

    task automatic cyc(input logic iv, input logic [NP-1:0] g, input logic rv,
                       input logic [DW-1:0] d, input logic [NP-1:0] ordy);
        i_issue_valid = iv;
        i_issue_grant = g;
        i_rsp_valid   = rv;
        i_rsp_data    = d;
        i_out_ready   = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((mq.size() > 0 || m_hv) && guard < 200) begin
            cyc(1'b0, '0, (mq.size() > 0), rnd_data(), 2'b11);
            guard++;
        end
        cyc(1'b0, '0, 1'b0, '0, 2'b11);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cyc(1'b0, '0, 1'b0, '0, 2'b00);
        i_reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        i_reset       = 1'b1;
        i_issue_valid = 1'b0;
        i_issue_grant = '0;
        i_rsp_valid   = 1'b0;
        i_rsp_data    = '0;
        i_out_ready   = '0;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        cyc(1'b0, '0, 1'b0, '0, 2'b11);

        // Single port, in order.
        repeat (3) cyc(1'b1, 2'b01, 1'b0, '0, 2'b11);
        v = DW'(32'hA); cyc(1'b0, '0, 1'b1, v, 2'b11);
        v = DW'(32'hB); cyc(1'b0, '0, 1'b1, v, 2'b11);
        v = DW'(32'hC); cyc(1'b0, '0, 1'b1, v, 2'b11);
        repeat (2) cyc(1'b0, '0, 1'b0, '0, 2'b11);

        // Interleaved routing.
        cyc(1'b1, 2'b01, 1'b0, '0, 2'b11);
        cyc(1'b1, 2'b10, 1'b0, '0, 2'b11);
        cyc(1'b1, 2'b10, 1'b0, '0, 2'b11);
        cyc(1'b1, 2'b01, 1'b0, '0, 2'b11);
        for (int i = 0; i < 4; i++) begin
            v = DW'(32'hD0 + i);
            cyc(1'b0, '0, 1'b1, v, 2'b11);
        end
        repeat (2) cyc(1'b0, '0, 1'b0, '0, 2'b11);

        // Backpressure on port 1 with a second response waiting.
        cyc(1'b1, 2'b10, 1'b0, '0, 2'b11);
        cyc(1'b1, 2'b01, 1'b0, '0, 2'b11);
        cyc(1'b0, '0, 1'b1, rnd_data(), 2'b01);
        repeat (5) cyc(1'b0, '0, 1'b1, rnd_data(), 2'b01);
        cyc(1'b0, '0, 1'b1, rnd_data(), 2'b11);
        drain();

        // Fill to full, attempt an extra issue, then overlap pops with refills to wrap.
        for (int i = 0; i < MO; i++) cyc(1'b1, rnd_onehot(), 1'b0, '0, 2'b11);
        cyc(1'b1, rnd_onehot(), 1'b0, '0, 2'b11);
        for (int i = 0; i < MO + 1; i++) cyc(1'b1, rnd_onehot(), 1'b1, rnd_data(), 2'b11);
        drain();

        // Error cases: response with nothing outstanding, multi-hot grant, zero grant.
        cyc(1'b0, '0, 1'b1, rnd_data(), 2'b11);
        cyc(1'b0, '0, 1'b0, '0, 2'b11);
        cyc(1'b1, 2'b11, 1'b0, '0, 2'b11);
        cyc(1'b1, 2'b00, 1'b0, '0, 2'b11);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(1, 0)), rnd_onehot(),
                1'($urandom_range(2, 0) != 0), rnd_data(), 2'($urandom_range(3, 0)));
        end
        drain();

        // Reset mid-stream with a held response and outstanding tags.
        do_reset();
        cyc(1'b0, '0, 1'b0, '0, 2'b11);
        repeat (6) cyc(1'b1, rnd_onehot(), 1'b0, '0, 2'b00);
        cyc(1'b0, '0, 1'b1, rnd_data(), 2'b00);
        cyc(1'b1, 2'b00, 1'b0, '0, 2'b00);
        do_reset();
        repeat (3) cyc(1'b0, '0, 1'b0, '0, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
